// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / instruction-buffer path.
package fetch_pkg;

    // One buffered instruction together with its PC.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } fetch_entry_t;

    // RV32I canonical NOP (addi x0, x0, 0); used as filler on idle fetch lanes.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_buffer.sv
// Dual-issue instruction buffer between fetch and decode.
// Accepts up to two instructions per cycle and presents the two oldest
// entries in program order. The fetch throttle comes from registered
// occupancy only. A taken branch or reset discards all contents.
module instr_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] instructionA,
    input  logic [31:0] instructionB,
    input  logic [31:0] addressA,
    input  logic [31:0] addressB,
    input  logic        instructionA_valid,
    input  logic        instructionB_valid,
    output logic        stall,
    output logic [31:0] issue0_instr,
    output logic [31:0] issue0_addr,
    output logic        issue0_valid,
    input  logic        issue0_ready,
    output logic [31:0] issue1_instr,
    output logic [31:0] issue1_addr,
    output logic        issue1_valid,
    input  logic        issue1_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Two write ports and two read ports per cycle, so this stays a plain
    // register array rather than block RAM.
    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push_a;
    logic            w_push_b;
    logic [1:0]      w_nin;
    logic [1:0]      w_nout;
    logic            w_pop0;
    logic            w_pop1;
    logic            w_has1;
    logic            w_has2;
    logic [PW-1:0]   w_rd_ptr1;
    logic [PW-1:0]   w_wr_ptr1;
    fetch_entry_t    w_head0;
    fetch_entry_t    w_head1;

    // Push qualification: B is only accepted alongside A.
    always_comb begin
        w_push_a = instructionA_valid;
        w_push_b = instructionA_valid & instructionB_valid;
        w_nin    = {1'b0, w_push_a} + {1'b0, w_push_b};
    end

    // Occupancy-derived status. Stall depends on the registered count only,
    // because the fetcher gates its valids with it.
    always_comb begin
        w_has1 = (r_count != '0);
        w_has2 = (r_count >= CW'(2));
        stall  = (r_count >= CW'(DEPTH - 1));
    end

    // Read side: slot 0 is the oldest entry, slot 1 the next one.
    // Valids are suppressed while the buffer is being discarded.
    always_comb begin
        w_rd_ptr1    = r_rd_ptr + PW'(1);
        w_head0      = r_mem[r_rd_ptr];
        w_head1      = r_mem[w_rd_ptr1];
        issue0_valid = w_has1 & ~flush & ~reset;
        issue1_valid = w_has2 & ~flush & ~reset;
        issue0_instr = w_has1 ? w_head0.instr : '0;
        issue0_addr  = w_has1 ? w_head0.addr  : '0;
        issue1_instr = w_has2 ? w_head1.instr : '0;
        issue1_addr  = w_has2 ? w_head1.addr  : '0;
    end

    // Retirement: slot 1 only retires together with slot 0 to keep order.
    always_comb begin
        w_pop0 = issue0_valid & issue0_ready;
        w_pop1 = w_pop0 & issue1_valid & issue1_ready;
        w_nout = {1'b0, w_pop0} + {1'b0, w_pop1};
    end

    // Pointer and occupancy update; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_nin);
            r_rd_ptr <= r_rd_ptr + PW'(w_nout);
            r_count  <= r_count + CW'(w_nin) - CW'(w_nout);
        end
    end

    assign w_wr_ptr1 = r_wr_ptr + PW'(1);

    // Entry writes: A at the write pointer, B right after it (wraps freely).
    // Wrong-path pushes in a flush or reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (w_push_a) begin
                r_mem[r_wr_ptr] <= '{instr: instructionA, addr: addressA};
            end
            if (w_push_b) begin
                r_mem[w_wr_ptr1] <= '{instr: instructionB, addr: addressB};
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer (DEPTH=8).
module tb_instr_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] instructionA, instructionB, addressA, addressB;
    logic        instructionA_valid, instructionB_valid;
    logic        stall;
    logic [31:0] issue0_instr, issue0_addr, issue1_instr, issue1_addr;
    logic        issue0_valid, issue1_valid;
    logic        issue0_ready, issue1_ready;

    int total = 0;
    int bad   = 0;

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .instructionA       (instructionA),
        .instructionB       (instructionB),
        .addressA           (addressA),
        .addressB           (addressB),
        .instructionA_valid (instructionA_valid),
        .instructionB_valid (instructionB_valid),
        .stall              (stall),
        .issue0_instr       (issue0_instr),
        .issue0_addr        (issue0_addr),
        .issue0_valid       (issue0_valid),
        .issue0_ready       (issue0_ready),
        .issue1_instr       (issue1_instr),
        .issue1_addr        (issue1_addr),
        .issue1_valid       (issue1_valid),
        .issue1_ready       (issue1_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, av, bv;
        logic [31:0] ia, aa, ib, ab;
        logic        r0, r1;
        logic        e_stall, e_v0, e_v1, e_zero;
        logic [31:0] e_i0, e_a0, e_i1, e_a1;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    fetch_entry_t q [$];

    function automatic logic [31:0] ins(input int n);
        return 32'h1000_0000 + n;
    endfunction

    function automatic vec_t mk(input logic fl, av, bv,
                                input logic [31:0] ia, aa, ib, ab,
                                input logic r0, r1, es, ev0, ev1, ez,
                                input logic [31:0] ei0, ea0, ei1, ea1);
        vec_t v;
        v.fl = fl; v.av = av; v.bv = bv;
        v.ia = ia; v.aa = aa; v.ib = ib; v.ab = ab;
        v.r0 = r0; v.r1 = r1;
        v.e_stall = es; v.e_v0 = ev0; v.e_v1 = ev1; v.e_zero = ez;
        v.e_i0 = ei0; v.e_a0 = ea0; v.e_i1 = ei1; v.e_a1 = ea1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        instructionA_valid = 1'b0; instructionB_valid = 1'b0;
        instructionA = NOP_INSTR; instructionB = NOP_INSTR;
        addressA = '0; addressB = '0;
    endtask

    // Protocol and wrong-path monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (instructionA_valid && stall) begin
                bad++;
                $display("FAIL push_while_stall got=1 want=0");
            end
            total++;
            if ((issue0_valid && (issue0_instr[31:16] == 16'hDEAD || issue0_instr[31:16] == 16'hBAD0)) ||
                (issue1_valid && (issue1_instr[31:16] == 16'hDEAD || issue1_instr[31:16] == 16'hBAD0))) begin
                bad++;
                $display("FAIL wrong_path_issue got=%h/%h want=none", issue0_instr, issue1_instr);
            end
        end
    end

    initial begin
        // Hand-computed vectors: inputs for the cycle, outputs expected mid-cycle.
        vecs[0]  = mk(0,1,1, 32'h0010_0093,32'h0, 32'h0020_0113,32'h4, 1,1, 0,0,0,1, 0,0,0,0);
        vecs[1]  = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,1, 0,1,1,0, 32'h0010_0093,32'h0, 32'h0020_0113,32'h4);
        vecs[2]  = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,1, 0,0,0,1, 0,0,0,0);
        vecs[3]  = mk(0,1,1, ins(1),32'h100, ins(2),32'h104, 0,0, 0,0,0,1, 0,0,0,0);
        vecs[4]  = mk(0,1,1, ins(3),32'h108, ins(4),32'h10C, 0,0, 0,1,1,0, ins(1),32'h100, ins(2),32'h104);
        vecs[5]  = mk(0,1,1, ins(5),32'h110, ins(6),32'h114, 0,0, 0,1,1,0, ins(1),32'h100, ins(2),32'h104);
        vecs[6]  = mk(0,1,1, ins(7),32'h118, ins(8),32'h11C, 0,0, 0,1,1,0, ins(1),32'h100, ins(2),32'h104);
        vecs[7]  = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,0, 1,1,1,0, ins(1),32'h100, ins(2),32'h104);
        vecs[8]  = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 0,1, 1,1,1,0, ins(2),32'h104, ins(3),32'h108);
        vecs[9]  = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 0,1, 1,1,1,0, ins(2),32'h104, ins(3),32'h108);
        vecs[10] = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 0,1, 1,1,1,0, ins(2),32'h104, ins(3),32'h108);
        vecs[11] = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,0, 1,1,1,0, ins(2),32'h104, ins(3),32'h108);
        vecs[12] = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,0, 0,1,1,0, ins(3),32'h108, ins(4),32'h10C);
        vecs[13] = mk(1,1,1, 32'hDEAD_0040,32'h40, 32'hDEAD_0044,32'h44, 1,1, 0,0,0,0, 0,0,0,0);
        vecs[14] = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,1, 0,0,0,1, 0,0,0,0);
        vecs[15] = mk(0,0,0, NOP_INSTR,0, NOP_INSTR,0, 1,1, 0,0,0,1, 0,0,0,0);

        idle_inputs();
        reset = 1'b1;
        issue0_ready = 1'b0; issue1_ready = 1'b0;
        tick(); tick();
        #4;
        chk("rst.v0", 32'(issue0_valid), 0);
        chk("rst.v1", 32'(issue1_valid), 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            #4;
            chk($sformatf("idle%0d.stall", i), 32'(stall), 0);
            chk($sformatf("idle%0d.v0", i), 32'(issue0_valid), 0);
            chk($sformatf("idle%0d.v1", i), 32'(issue1_valid), 0);
            tick();
        end

        for (int i = 0; i < NV; i++) begin
            flush = vecs[i].fl;
            instructionA_valid = vecs[i].av; instructionB_valid = vecs[i].bv;
            instructionA = vecs[i].ia; addressA = vecs[i].aa;
            instructionB = vecs[i].ib; addressB = vecs[i].ab;
            issue0_ready = vecs[i].r0; issue1_ready = vecs[i].r1;
            #4;
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d.v0", i), 32'(issue0_valid), 32'(vecs[i].e_v0));
            chk($sformatf("v%0d.v1", i), 32'(issue1_valid), 32'(vecs[i].e_v1));
            if (vecs[i].e_v0) begin
                chk($sformatf("v%0d.i0", i), issue0_instr, vecs[i].e_i0);
                chk($sformatf("v%0d.a0", i), issue0_addr,  vecs[i].e_a0);
            end
            if (vecs[i].e_v1) begin
                chk($sformatf("v%0d.i1", i), issue1_instr, vecs[i].e_i1);
                chk($sformatf("v%0d.a1", i), issue1_addr,  vecs[i].e_a1);
            end
            if (vecs[i].e_zero) begin
                chk($sformatf("v%0d.zi0", i), issue0_instr, 0);
                chk($sformatf("v%0d.za0", i), issue0_addr,  0);
                chk($sformatf("v%0d.zi1", i), issue1_instr, 0);
                chk($sformatf("v%0d.za1", i), issue1_addr,  0);
            end
            tick();
        end

        // Queue-model sequence across pointer wrap: A-only pushes with
        // interleaved B-only junk, then dual pushes, with varying readies.
        // The buffer is empty with both pointers at 0 here.
        idle_inputs();
        q.delete();
        for (int c = 0; c < 32; c++) begin
            logic m_v0, m_v1, m_p0, m_p1;
            fetch_entry_t e;
            idle_inputs();
            issue0_ready = (c % 2 == 0);
            issue1_ready = (c % 3 != 0);
            if (q.size() <= DEPTH - 2) begin
                if (c < 20) begin
                    if (c % 5 == 4) begin
                        instructionB_valid = 1'b1;
                        instructionB = 32'hBAD0_0000 + c;
                        addressB = 32'h800 + c;
                    end else begin
                        instructionA_valid = 1'b1;
                        instructionA = 32'hA000_0000 + c;
                        addressA = 32'h4 + 32'(8 * c);
                    end
                end else begin
                    instructionA_valid = 1'b1; instructionB_valid = 1'b1;
                    instructionA = 32'hC000_0000 + c; addressA = 32'h300 + 32'(8 * c);
                    instructionB = 32'hC100_0000 + c; addressB = 32'h304 + 32'(8 * c);
                end
            end
            #4;
            m_v0 = (q.size() >= 1);
            m_v1 = (q.size() >= 2);
            chk($sformatf("m%0d.stall", c), 32'(stall), 32'(q.size() >= DEPTH - 1));
            chk($sformatf("m%0d.v0", c), 32'(issue0_valid), 32'(m_v0));
            chk($sformatf("m%0d.v1", c), 32'(issue1_valid), 32'(m_v1));
            if (m_v0) begin
                chk($sformatf("m%0d.i0", c), issue0_instr, q[0].instr);
                chk($sformatf("m%0d.a0", c), issue0_addr,  q[0].addr);
            end
            if (m_v1) begin
                chk($sformatf("m%0d.i1", c), issue1_instr, q[1].instr);
                chk($sformatf("m%0d.a1", c), issue1_addr,  q[1].addr);
            end
            m_p0 = m_v0 & issue0_ready;
            m_p1 = m_p0 & m_v1 & issue1_ready;
            if (m_p0) void'(q.pop_front());
            if (m_p1) void'(q.pop_front());
            if (instructionA_valid) begin
                e.instr = instructionA; e.addr = addressA;
                q.push_back(e);
                if (instructionB_valid) begin
                    e.instr = instructionB; e.addr = addressB;
                    q.push_back(e);
                end
            end
            tick();
        end

        // Mid-operation reset discards contents.
        idle_inputs();
        issue0_ready = 1'b0; issue1_ready = 1'b0;
        flush = 1'b1;
        #4;
        chk("fl2.v0", 32'(issue0_valid), 0);
        tick();
        idle_inputs();
        instructionA_valid = 1'b1; instructionB_valid = 1'b1;
        instructionA = 32'h2000_0000; addressA = 32'h200;
        instructionB = 32'h2000_0001; addressB = 32'h204;
        #4;
        tick();
        instructionA = 32'h2000_0002; addressA = 32'h208;
        instructionB = 32'h2000_0003; addressB = 32'h20C;
        #4;
        chk("pre_rst.v1", 32'(issue1_valid), 1);
        chk("pre_rst.i0", issue0_instr, 32'h2000_0000);
        tick();
        idle_inputs();
        reset = 1'b1;
        issue0_ready = 1'b1; issue1_ready = 1'b1;
        #4;
        chk("mid_rst.v0", 32'(issue0_valid), 0);
        chk("mid_rst.v1", 32'(issue1_valid), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #4;
            chk($sformatf("post_rst%0d.stall", i), 32'(stall), 0);
            chk($sformatf("post_rst%0d.v0", i), 32'(issue0_valid), 0);
            chk($sformatf("post_rst%0d.v1", i), 32'(issue1_valid), 0);
            chk($sformatf("post_rst%0d.i0", i), issue0_instr, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_buffer.md
# instr_buffer

Dual-issue instruction buffer and fetch-throttle controller. Sits between the instruction fetcher and decode. Accepts up to two instruction/address pairs per cycle and returns up to two in program order through a valid/ready issue interface. Drives the fetcher's `stall` from its own occupancy and discards all contents on a taken branch.

## Interface
Parameters:
- `DEPTH`, default 8. Number of entries; power of two, ≥4.

Ports:
- `clk`  in  1  — single clock, all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `flush`  in  1  — taken-branch redirect; wired to `branchTaken`.
- `instructionA`, `instructionB`  in  32 each  — fetched instructions.
- `addressA`, `addressB`  in  32 each  — their PCs.
- `instructionA_valid`, `instructionB_valid`  in  1 each  — push qualifiers.
- `stall`  out  1  — fetch throttle to the fetcher.
- `issue0_instr`, `issue0_addr`  out  32 each  — oldest entry.
- `issue0_valid`  out  1
- `issue0_ready`  in  1
- `issue1_instr`, `issue1_addr`  out  32 each  — second-oldest entry.
- `issue1_valid`  out  1
- `issue1_ready`  in  1

## Operation
State:
- Circular entry array of {instr, addr}.
- `rd_ptr` and `wr_ptr`, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
- `count`, `$clog2(DEPTH)+1` bits, range 0..DEPTH.

Push:
- `nin` = A_valid + (A_valid & B_valid).
- B without A is ignored.
- A is written at `wr_ptr`, B at `wr_ptr+1`.
- `wr_ptr` advances by `nin`.

Stall:
- `stall = (DEPTH - count) < 2`.
- It is a function of registered `count` only. It must have no combinational path from any input, because the fetcher gates its valids with `!stall`.
- A push arriving while `stall`=1 is a protocol error; the bench asserts it never happens.

Issue:
- `issue0_valid = count≥1 & !flush`.
- `issue1_valid = count≥2 & !flush`.
- `issue0_*` reads `rd_ptr`; `issue1_*` reads `rd_ptr+1`.
- `pop0 = issue0_valid & issue0_ready`.
- `pop1 = pop0 & issue1_valid & issue1_ready`. In-order rule: slot 1 never retires without slot 0.
- `nout = pop0 + pop1`. `rd_ptr` advances by `nout`.

Count update:
- `count <= count + nin - nout`. Push and pop in the same cycle are legal.
- No bypass: a pushed entry is first visible at issue the next cycle.

Flush (priority below reset, above push/pop):
- `rd_ptr`, `wr_ptr`, `count` go to 0.
- Pushes in the flush cycle are dropped; they are wrong-path.
- Issue valids are forced 0 in the flush cycle.

Reset:
- Same effect as flush.
- Outputs during and after reset: `stall`=0, both valids 0.
- Data outputs are don't-care when invalid; drive 0 when count==0.
- Reset mid-operation discards all entries.

## Timing
- Push at edge N → entry can issue in cycle N+1.
- `stall` reflects the occupancy after edge N throughout cycle N+1.
- Issue outputs are combinational from registers plus `flush`. The handshake is same-cycle: valid & ready at edge → retired.
- Full boundary: `count`==DEPTH-1 or DEPTH → `stall`=1. A pop-only cycle at count==DEPTH-1 makes `stall`=0 the next cycle.
- Empty boundary: `count`==0 → both valids 0. `count`==1 → only `issue0_valid`.
- Wrap-around: B written at index DEPTH-1 and A at index 0 (or vice versa) wrap with no bubble.

## Structure
- Shared package `fetch_pkg`:
  - typedef `fetch_entry_t` {logic [31:0] instr; logic [31:0] addr;}
  - localparam `NOP_INSTR` = 32'h0000_0013, for the bench filler.
- Single module; no sub-module needed. Storage is a plain register array with two write ports and two read ports. Do not map it to EBR, because two writes are needed per cycle.

## Test plan
- Reset then idle: `stall`=0, `issue0_valid`=`issue1_valid`=0 for 5 cycles.
- Dual push A=0x00100093@0x0 and B=0x00200113@0x4 with both readies high → next cycle slot0=0x00100093/0x0 and slot1=0x00200113/0x4. Both retire; count returns to 0.
- DEPTH=8, readies low, 4 dual pushes → after the 3rd, count=6 and `stall`=0. After the 4th, count=8 and `stall`=1. Assert `issue0_ready` for one cycle → count=7, `stall` stays 1.
- `issue1_ready`=1 with `issue0_ready`=0 for 3 cycles → no retirement; count unchanged.
- Count=5 with `flush`=1 and a simultaneous dual push → valids 0 that cycle. Next cycle count=0, `stall`=0, and the pushed PCs 0x40/0x44 never issue.
- Single pushes with A only (PCs 0x4, 0xC, 0x14, …) for 20 cycles, alternating readies → issue order matches push order across the pointer wrap. The B-only input pattern never enters the buffer.
